// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared types for the pipeline stall/flush controller.
//   pipe_state_t     : registered freeze state exposed on pipe_ctrl_unit.state_o
//   pipe_ctrl_struct : per-stage pipeline register load enables
//   reg_hit()        : one source-operand versus destination-register compare
package pipe_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL_I  = 2'd1,
    STALL_D  = 2'd2,
    STALL_ID = 2'd3
  } pipe_state_t;

  typedef struct packed {
    logic ifid_ld;
    logic idex_ld;
    logic exmem_ld;
    logic memwb_ld;
  } pipe_ctrl_struct;

  localparam pipe_ctrl_struct PIPE_ALL_LD = 4'b1111;
  localparam pipe_ctrl_struct PIPE_HOLD   = 4'b0000;
  // A load-use bubble holds IF/ID and PC and lets everything from ID/EX onward advance.
  localparam pipe_ctrl_struct PIPE_BUBBLE = 4'b0111;

  function automatic logic reg_hit(input logic use_rs, input logic [4:0] rs,
                                   input logic [4:0] rd);
    return use_rs && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the controller's performance statistics.
// Ports:
//   clk   : clock
//   clr_n : synchronous active-low clear (dominates inc)
//   inc   : add one this cycle unless already all-ones
//   count : current value
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Central stall/flush controller of a 5-stage RV32I pipeline.
// Freezes the whole pipe while an I$ or D$ request is outstanding, inserts a
// bubble on a load-use hazard, squashes IF/ID and ID/EX on an EX redirect, and
// keeps saturating statistics plus a sticky stall-timeout flag.
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   icache_read/icache_resp   : fetch request outstanding / I$ data valid
//   mem_dcache_rd/_wr         : D$ access in MEM; dcache_resp completes it
//   ex_dcache_rd, ex_rd       : load sitting in EX and its destination
//   id_rs1/2, id_use_rs1/2    : source operands of the instruction in ID
//   ex_redirect               : branch taken / jump resolved in EX
//   pipe_ctrl, pc_ld          : stage load enables and PC load (combinational)
//   ifid_flush, idex_flush    : load a NOP into IF/ID or ID/EX (combinational)
//   state_o                   : registered freeze state (RUN/STALL_I/STALL_D/STALL_ID)
//   stall_cnt/bubble_cnt/flush_cnt : saturating event counters
//   stall_timeout             : sticky, set after TIMEOUT consecutive non-RUN cycles
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            icache_read,
  input  logic            icache_resp,
  input  logic            mem_dcache_rd,
  input  logic            mem_dcache_wr,
  input  logic            dcache_resp,
  input  logic            ex_dcache_rd,
  input  logic [4:0]      ex_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_redirect,
  output pipe_ctrl_struct pipe_ctrl,
  output logic            pc_ld,
  output logic            ifid_flush,
  output logic            idex_flush,
  output pipe_state_t     state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic            stall_timeout
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] TIMEOUT_V = RUN_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

  // Cache handshake: a request is outstanding in every cycle its read/write
  // line is high; the resp cycle completes it and releases the freeze in that
  // same cycle. A cache that answers early keeps its data until the other
  // side finishes, so nothing is re-issued while both are pending.
  logic i_pend, d_pend, freeze, lu, redirect_go, bubble_go;

  assign i_pend = icache_read & ~icache_resp;
  assign d_pend = (mem_dcache_rd | mem_dcache_wr) & ~dcache_resp;
  assign freeze = i_pend | d_pend;

  // x0 is never a real dependency.
  assign lu = ex_dcache_rd && (ex_rd != 5'd0) &&
              (reg_hit(id_use_rs1, id_rs1, ex_rd) || reg_hit(id_use_rs2, id_rs2, ex_rd));

  // A redirect seen during a freeze is dropped: EX is held, so the same
  // redirect is presented again on the release cycle.
  assign redirect_go = ~freeze & ex_redirect;
  assign bubble_go   = ~freeze & ~ex_redirect & lu;

  always_comb begin
    pipe_ctrl  = PIPE_ALL_LD;
    pc_ld      = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst) begin
      pipe_ctrl  = PIPE_HOLD;
      pc_ld      = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (freeze) begin
      pipe_ctrl = PIPE_HOLD;
      pc_ld     = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pipe_ctrl  = PIPE_BUBBLE;
      pc_ld      = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Freeze-state FSM: the next state is purely the current pend flags.
  pipe_state_t state_q, state_d;

  always_comb begin
    state_d = RUN;
    unique case ({d_pend, i_pend})
      2'b00:   state_d = RUN;
      2'b01:   state_d = STALL_I;
      2'b10:   state_d = STALL_D;
      default: state_d = STALL_ID;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  assign state_o = state_q;

  // Run length of consecutive non-RUN registered states; saturates at TIMEOUT
  // so it never wraps during an arbitrarily long hang.
  logic [RUN_W-1:0] run_len;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_len       <= '0;
      stall_timeout <= 1'b0;
    end else if (state_q != RUN) begin
      if (run_len != TIMEOUT_V) run_len <= run_len + RUN_ONE;
      if (run_len == TIMEOUT_V - RUN_ONE) stall_timeout <= 1'b1;
    end else begin
      run_len <= '0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .clr_n(rst), .inc(freeze), .count(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .clr_n(rst), .inc(bubble_go), .count(bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .clr_n(rst), .inc(redirect_go), .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit. Inputs change 2 time units after each rising
// edge; combinational outputs are sampled 1 unit later, registered outputs
// 2 units after the next rising edge.
module tb_pipe_ctrl_unit;

  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 8;
  localparam int MAXC    = (1 << CNT_W) - 1;

  // Clock / reset / DUT signals
  logic clk = 1'b0;
  logic rst;
  logic icache_read, icache_resp;
  logic mem_dcache_rd, mem_dcache_wr, dcache_resp;
  logic ex_dcache_rd;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic id_use_rs1, id_use_rs2, ex_redirect;
  logic [3:0] pipe_ctrl;
  logic pc_ld, ifid_flush, idex_flush;
  logic [1:0] state_o;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
  logic stall_timeout;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_resp(icache_resp),
    .mem_dcache_rd(mem_dcache_rd), .mem_dcache_wr(mem_dcache_wr),
    .dcache_resp(dcache_resp),
    .ex_dcache_rd(ex_dcache_rd), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_redirect(ex_redirect),
    .pipe_ctrl(pipe_ctrl), .pc_ld(pc_ld),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .state_o(state_o),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
    .stall_timeout(stall_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_state, m_stall, m_bubble, m_flush, m_run;
  bit m_to;

  logic [6:0] obs_comb;
  logic [CNT_W*3+2:0] obs_regs;
  assign obs_comb = {pipe_ctrl, pc_ld, ifid_flush, idex_flush};
  assign obs_regs = {state_o, stall_timeout, stall_cnt, bubble_cnt, flush_cnt};

  function automatic bit f_ip();
    return icache_read && !icache_resp;
  endfunction

  function automatic bit f_dp();
    return (mem_dcache_rd || mem_dcache_wr) && !dcache_resp;
  endfunction

  function automatic bit f_lu();
    return ex_dcache_rd && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  // {pipe_ctrl, pc_ld, ifid_flush, idex_flush} by priority rules
  function automatic logic [6:0] exp_comb();
    if (!rst)               return 7'b0000_0_1_1;
    if (f_ip() || f_dp())   return 7'b0000_0_0_0;
    if (ex_redirect)        return 7'b1111_1_1_1;
    if (f_lu())             return 7'b0111_0_0_1;
    return 7'b1111_1_0_0;
  endfunction

  function automatic logic [CNT_W*3+2:0] exp_regs();
    return {2'(m_state), m_to, CNT_W'(m_stall), CNT_W'(m_bubble), CNT_W'(m_flush)};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  // Driver: advance one clock, updating the model from the inputs seen before the edge.
  task automatic advance();
    bit ip, dp, lu, rd, rs;
    ip = f_ip(); dp = f_dp(); lu = f_lu(); rd = ex_redirect; rs = rst;
    @(posedge clk);
    if (!rs) begin
      m_state = 0; m_stall = 0; m_bubble = 0; m_flush = 0; m_run = 0; m_to = 0;
    end else begin
      if (m_state != 0) begin
        if (m_run < TIMEOUT) m_run++;
        if (m_run == TIMEOUT) m_to = 1;
      end else begin
        m_run = 0;
      end
      m_state = (dp ? 2 : 0) + (ip ? 1 : 0);
      if (ip || dp)   m_stall  = sat_inc(m_stall);
      else if (rd)    m_flush  = sat_inc(m_flush);
      else if (lu)    m_bubble = sat_inc(m_bubble);
    end
    #2;
  endtask

  task automatic clear_inputs();
    icache_read = 0; icache_resp = 0;
    mem_dcache_rd = 0; mem_dcache_wr = 0; dcache_resp = 0;
    ex_dcache_rd = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_redirect = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 0;
    advance();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (obs_comb !== 7'b0000_0_1_1) begin
        n_fail++;
        $display("FAIL reset_comb cycle %0d: got %b want %b", i, obs_comb, 7'b0000011);
      end
      advance();
      n_tests++;
      if (obs_regs !== exp_regs()) begin
        n_fail++;
        $display("FAIL reset_regs cycle %0d: got %h want %h", i, obs_regs, exp_regs());
      end
    end
    rst = 1;
    #1;
    n_tests++;
    if (obs_comb !== 7'b1111_1_0_0) begin
      n_fail++;
      $display("FAIL release_comb: got %b want %b", obs_comb, 7'b1111100);
    end
    advance();
    n_tests++;
    if (state_o !== 2'd0 || stall_cnt !== '0 || bubble_cnt !== '0 ||
        flush_cnt !== '0 || stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL release_regs: got %h want all zero", obs_regs);
    end
  endtask

  task automatic test_icache_stall();
    apply_reset();
    icache_read = 1; icache_resp = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (obs_comb !== 7'b0000_0_0_0) begin
        n_fail++;
        $display("FAIL istall_comb cycle %0d: got %b want %b", i, obs_comb, 7'b0);
      end
      advance();
      n_tests++;
      if (state_o !== 2'd1 || obs_regs !== exp_regs()) begin
        n_fail++;
        $display("FAIL istall_regs cycle %0d: got %h want %h", i, obs_regs, exp_regs());
      end
    end
    icache_resp = 1;
    #1;
    n_tests++;
    if (obs_comb !== 7'b1111_1_0_0) begin
      n_fail++;
      $display("FAIL istall_release: got %b want %b", obs_comb, 7'b1111100);
    end
    advance();
    clear_inputs();
    n_tests++;
    if (stall_cnt !== CNT_W'(5) || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL istall_count: got cnt %0d state %0d want 5 0", stall_cnt, state_o);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_dcache_rd = 1; ex_rd = 5;
    id_rs1 = 3; id_use_rs1 = 1; id_rs2 = 5; id_use_rs2 = 1;
    #1;
    n_tests++;
    if (obs_comb !== 7'b0111_0_0_1) begin
      n_fail++;
      $display("FAIL loaduse_comb: got %b want %b", obs_comb, 7'b0111001);
    end
    advance();
    clear_inputs();
    #1;
    n_tests++;
    if (obs_comb !== 7'b1111_1_0_0) begin
      n_fail++;
      $display("FAIL loaduse_after: got %b want %b", obs_comb, 7'b1111100);
    end
    advance();
    n_tests++;
    if (bubble_cnt !== CNT_W'(1) || obs_regs !== exp_regs()) begin
      n_fail++;
      $display("FAIL loaduse_count: got %h want %h", obs_regs, exp_regs());
    end
  endtask

  task automatic test_redirect_frozen();
    apply_reset();
    ex_redirect = 1; mem_dcache_rd = 1; dcache_resp = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (obs_comb !== 7'b0000_0_0_0) begin
        n_fail++;
        $display("FAIL redir_frozen cycle %0d: got %b want %b", i, obs_comb, 7'b0);
      end
      advance();
    end
    dcache_resp = 1;
    #1;
    n_tests++;
    if (obs_comb !== 7'b1111_1_1_1) begin
      n_fail++;
      $display("FAIL redir_release: got %b want %b", obs_comb, 7'b1111111);
    end
    advance();
    clear_inputs();
    n_tests++;
    if (flush_cnt !== CNT_W'(1) || stall_cnt !== CNT_W'(3) || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL redir_counts: got flush %0d stall %0d state %0d want 1 3 0",
               flush_cnt, stall_cnt, state_o);
    end
  endtask

  task automatic test_lu_corners();
    apply_reset();
    ex_dcache_rd = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 1; id_use_rs2 = 1;
    #1;
    n_tests++;
    if (obs_comb !== 7'b1111_1_0_0) begin
      n_fail++;
      $display("FAIL lu_x0: got %b want %b", obs_comb, 7'b1111100);
    end
    advance();
    ex_rd = 9; id_rs1 = 9; ex_redirect = 1;
    #1;
    n_tests++;
    if (obs_comb !== 7'b1111_1_1_1) begin
      n_fail++;
      $display("FAIL lu_vs_redirect: got %b want %b", obs_comb, 7'b1111111);
    end
    advance();
    clear_inputs();
    n_tests++;
    if (bubble_cnt !== '0 || flush_cnt !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL lu_corner_counts: got bubble %0d flush %0d want 0 1", bubble_cnt, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_dcache_wr = 1; dcache_resp = 0;
    for (int k = 1; k <= 12; k++) begin
      advance();
      n_tests++;
      if (stall_timeout !== (k >= TIMEOUT + 1) || obs_regs !== exp_regs()) begin
        n_fail++;
        $display("FAIL timeout edge %0d: got to %b regs %h want to %b regs %h",
                 k, stall_timeout, obs_regs, (k >= TIMEOUT + 1), exp_regs());
      end
    end
    dcache_resp = 1;
    advance();
    clear_inputs();
    for (int i = 0; i < 3; i++) advance();
    n_tests++;
    if (stall_timeout !== 1'b1 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_sticky: got to %b state %0d want 1 0", stall_timeout, state_o);
    end
    // Reset in the middle of a combined stall
    icache_read = 1; mem_dcache_rd = 1;
    advance();
    advance();
    n_tests++;
    if (state_o !== 2'd3) begin
      n_fail++;
      $display("FAIL stall_id_state: got %0d want 3", state_o);
    end
    rst = 0;
    advance();
    rst = 1;
    clear_inputs();
    n_tests++;
    if (state_o !== 2'd0 || stall_cnt !== '0 || flush_cnt !== '0 ||
        bubble_cnt !== '0 || stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL midstall_reset: got %h want all zero", obs_regs);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    icache_read = 1; icache_resp = 0;
    for (int i = 0; i < MAXC + 3; i++) advance();
    n_tests++;
    if (stall_cnt !== CNT_W'(MAXC)) begin
      n_fail++;
      $display("FAIL stall_saturate: got %0d want %0d", stall_cnt, MAXC);
    end
    clear_inputs();
    advance();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 59) != 0);
      icache_read   = $urandom_range(0, 1);
      icache_resp   = $urandom_range(0, 1);
      mem_dcache_rd = ($urandom_range(0, 3) == 0);
      mem_dcache_wr = ($urandom_range(0, 5) == 0);
      dcache_resp   = $urandom_range(0, 1);
      ex_dcache_rd  = $urandom_range(0, 1);
      ex_rd         = 5'($urandom_range(0, 3));
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = $urandom_range(0, 1);
      id_use_rs2    = $urandom_range(0, 1);
      ex_redirect   = ($urandom_range(0, 4) == 0);
      #1;
      n_tests++;
      if (obs_comb !== exp_comb()) begin
        n_fail++;
        $display("FAIL rand_comb iter %0d: got %b want %b", i, obs_comb, exp_comb());
      end
      advance();
      n_tests++;
      if (obs_regs !== exp_regs()) begin
        n_fail++;
        $display("FAIL rand_regs iter %0d: got %h want %h", i, obs_regs, exp_regs());
      end
    end
    rst = 1;
    clear_inputs();
  endtask

  initial begin
    m_state = 0; m_stall = 0; m_bubble = 0; m_flush = 0; m_run = 0; m_to = 0;
    test_reset();
    test_icache_stall();
    test_load_use();
    test_redirect_frozen();
    test_lu_corners();
    test_timeout();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
